// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the 5-stage MIPS core (between EX and WB).
//
// Registers the EX->MEM bus under stall/flush control, captures synchronous
// SRAM load data and holds it across WB stalls, performs byte/half lane select
// with sign/zero extension, and drives the MEM->WB and MEM->ID forwarding buses.
//
// Optional feature macro: MEM_ALIGN_CHK_EN
//   defined   -> misaligned LW/LH/LHU raise mem_excp and suppress rf_we
//   undefined -> mem_excp tied to 0, rf_we never gated
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int STALL_IDX = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [78:0] ex_to_mem_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_rf_bus,
    output logic        mem_excp
);

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100
    } mem_op_e;

    // Field layout of the EX->MEM bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        mem_op_e     mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    ex_mem_t     bus_r;
    logic        first_cycle;
    logic [31:0] rdata_hold;

    logic        bubble;
    logic        advance;
    logic [31:0] rd;
    logic [1:0]  addr;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        rf_we_out;

    // An upstream stall with WB still moving must leave a bubble behind.
    assign bubble  = stall[STALL_IDX] && !stall[STALL_IDX+1];
    assign advance = !stall[STALL_IDX];

    // Pipeline input register and its "just loaded" marker.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            bus_r       <= '0;
            first_cycle <= 1'b0;
        end else if (flush || bubble) begin
            bus_r       <= '0;
            first_cycle <= 1'b0;
        end else if (advance) begin
            bus_r       <= ex_mem_t'(ex_to_mem_bus);
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
        end
    end

    // Capture SRAM data during the load's first MEM cycle so it survives WB stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_hold <= '0;
        end else if (first_cycle) begin
            rdata_hold <= data_sram_rdata;
        end
    end

    assign rd   = first_cycle ? data_sram_rdata : rdata_hold;
    assign addr = bus_r.ex_result[1:0];

    // Lane select and extension of the load data.
    always_comb begin
        // NOTE: load_data gets a default first so no path through the case can
        // leave it unassigned and infer a latch.
        load_data = rd;
        unique case (bus_r.mem_op)
            OP_LB, OP_LBU: begin
                logic [7:0] byte_v;
                case (addr)
                    2'd0:    byte_v = rd[7:0];
                    2'd1:    byte_v = rd[15:8];
                    2'd2:    byte_v = rd[23:16];
                    default: byte_v = rd[31:24];
                endcase
                if (bus_r.mem_op == OP_LB) begin
                    load_data = {{24{byte_v[7]}}, byte_v};
                end else begin
                    load_data = {24'd0, byte_v};
                end
            end
            OP_LH, OP_LHU: begin
                logic [15:0] half_v;
                half_v = addr[1] ? rd[31:16] : rd[15:0];
                if (bus_r.mem_op == OP_LH) begin
                    load_data = {{16{half_v[15]}}, half_v};
                end else begin
                    load_data = {16'd0, half_v};
                end
            end
            default: load_data = rd;
        endcase
    end

    assign rf_wdata = bus_r.sel_rf_res ? load_data : bus_r.ex_result;

`ifdef MEM_ALIGN_CHK_EN
    logic is_half;
    logic is_word;
    logic unused_fields;

    assign is_half  = (bus_r.mem_op == OP_LH) || (bus_r.mem_op == OP_LHU);
    // Encodings outside the defined set behave as LW.
    assign is_word  = !is_half && (bus_r.mem_op != OP_LB) && (bus_r.mem_op != OP_LBU);
    assign mem_excp = bus_r.data_ram_en && bus_r.sel_rf_res &&
                      ((is_word && (addr != 2'd0)) || (is_half && addr[0]));
    assign unused_fields = ^bus_r.data_ram_wen;
`else
    logic unused_fields;

    assign mem_excp      = 1'b0;
    assign unused_fields = ^{bus_r.data_ram_en, bus_r.data_ram_wen};
`endif

    assign rf_we_out = bus_r.rf_we && !mem_excp;

    assign mem_to_wb_bus = {bus_r.pc, rf_we_out, bus_r.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {rf_we_out, bus_r.rf_waddr, rf_wdata};

endmodule
